// File: rtl/sonic_measure.sv
// Ultrasonic range measurement: fires the sensor trigger, times the echo pulse
// and reports the distance in millimetres with a one-cycle o_read strobe.
module sonic_measure #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned CYCLES_PER_MM  = 292,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned HOLDOFF_CYCLES = 3000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_echo,
  output logic        o_trig,
  output logic [31:0] o_distance,
  output logic        o_read,
  output logic        o_idle,
  output logic        o_timeout
);

  localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_CYCLES - 1);
  localparam logic [31:0] CPM       = 32'(CYCLES_PER_MM);
  localparam logic [31:0] MM_MAX    = 32'hFFFF_FFFE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_ECHO,
    S_MEASURE,
    S_DONE,
    S_HOLDOFF
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] sub_q, sub_d;
  logic [31:0] mm_q, mm_d;
  logic        echo_m_q, echo_s_q, echo_d_q;
  logic        echo_rise;
  logic        res_to_d;
  logic [31:0] res_dist_d;
  logic        trig_q, read_q, idle_q, timeout_q;
  logic [31:0] dist_q;

  // Two-flop synchronizer for the asynchronous echo, plus one delay flop for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_m_q <= 1'b0;
      echo_s_q <= 1'b0;
      echo_d_q <= 1'b0;
    end else begin
      echo_m_q <= i_echo;
      echo_s_q <= echo_m_q;
      echo_d_q <= echo_s_q;
    end
  end

  assign echo_rise = echo_s_q & ~echo_d_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    sub_d    = sub_q;
    mm_d     = mm_q;
    res_to_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = 32'd0;
        if (i_start) state_d = S_TRIG;
      end
      S_TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = S_WAIT_ECHO;
          cnt_d   = 32'd0;
          tmo_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAIT_ECHO: begin
        tmo_d = tmo_q + 32'd1;
        if (tmo_q == TMO_LAST) begin
          state_d  = S_DONE;
          res_to_d = 1'b1;
        end else if (echo_rise) begin
          state_d = S_MEASURE;
          sub_d   = 32'd1;
          mm_d    = 32'd0;
        end
      end
      S_MEASURE: begin
        tmo_d = tmo_q + 32'd1;
        // Timeout is tested first so it wins over an echo falling in the same cycle.
        if (tmo_q == TMO_LAST) begin
          state_d  = S_DONE;
          res_to_d = 1'b1;
        end else if (!echo_s_q) begin
          state_d = S_DONE;
        end else if (sub_q + 32'd1 == CPM) begin
          sub_d = 32'd0;
          if (mm_q != MM_MAX) mm_d = mm_q + 32'd1;
        end else begin
          sub_d = sub_q + 32'd1;
        end
      end
      S_DONE: begin
        state_d = S_HOLDOFF;
        cnt_d   = 32'd0;
      end
      S_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign res_dist_d = res_to_d ? 32'hFFFF_FFFF : mm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 32'd0;
      tmo_q     <= 32'd0;
      sub_q     <= 32'd0;
      mm_q      <= 32'd0;
      trig_q    <= 1'b0;
      read_q    <= 1'b0;
      idle_q    <= 1'b1;
      timeout_q <= 1'b0;
      dist_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      sub_q   <= sub_d;
      mm_q    <= mm_d;
      trig_q  <= (state_d == S_TRIG);
      read_q  <= (state_d == S_DONE);
      idle_q  <= (state_d == S_IDLE);
      // Result registers load on entry to DONE so they are valid alongside o_read.
      if (state_d == S_DONE) begin
        dist_q    <= res_dist_d;
        timeout_q <= res_to_d;
      end
    end
  end

  assign o_trig     = trig_q;
  assign o_read     = read_q;
  assign o_idle     = idle_q;
  assign o_timeout  = timeout_q;
  assign o_distance = dist_q;

endmodule

// File: tb/tb_sonic_measure.sv
// Bench for sonic_measure: scripted and random echo pulses, expected results
// queued per measurement and compared whenever the DUT strobes o_read.
module tb_sonic_measure;

  localparam int TRIG = 5;
  localparam int CPM  = 10;
  localparam int TMO  = 200;
  localparam int HOLD = 20;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic        i_echo;
  logic        o_trig;
  logic [31:0] o_distance;
  logic        o_read;
  logic        o_idle;
  logic        o_timeout;

  always #5 clk = ~clk;

  sonic_measure #(
    .TRIG_CYCLES   (TRIG),
    .CYCLES_PER_MM (CPM),
    .TIMEOUT_CYCLES(TMO),
    .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_echo    (i_echo),
    .o_trig    (o_trig),
    .o_distance(o_distance),
    .o_read    (o_read),
    .o_idle    (o_idle),
    .o_timeout (o_timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Entry layout: {latency[15:0], timeout, distance[31:0]}
  logic [48:0] exp_q[$];
  bit          cont_chk = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  // Echo driven high d cycles after the trigger ends, for h cycles (h=0: no echo).
  // A result is valid only if the synchronized echo has ended before the last
  // cycle of the timeout window; otherwise the window expiry is reported.
  function automatic logic [48:0] model(input int d, input int h);
    int rise_at, fall_at;
    rise_at = d + SYNC;
    fall_at = rise_at + h;
    if (h > 0 && fall_at <= TMO - 2) return {16'(fall_at + 1), 1'b0, 32'(h / CPM)};
    return {16'(TMO), 1'b1, 32'hFFFF_FFFF};
  endfunction

  // ---------------- monitor ----------------
  longint      cyc = 0;
  longint      fall_cyc = 0;
  longint      read_cyc = 0;
  int          trig_w = 0;
  int          idle_cnt = 0;
  bit          in_trig = 1'b0;
  bit          have_read = 1'b0;
  logic [48:0] e;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_trig   = 1'b0;
      trig_w    = 0;
      have_read = 1'b0;
    end else begin
      if (o_trig) begin
        if (!in_trig && cont_chk && have_read) begin
          check("holdoff_gap", cyc - read_cyc, HOLD + 2);
          check("idle_cycles", idle_cnt, 1);
        end
        in_trig = 1'b1;
        trig_w++;
      end else if (in_trig) begin
        check("trig_width", trig_w, TRIG);
        in_trig  = 1'b0;
        trig_w   = 0;
        fall_cyc = cyc;
      end
      if (o_idle) idle_cnt++;
      if (o_read) begin
        check("read_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("distance", o_distance, e[31:0]);
          check("timeout_flag", o_timeout, e[32]);
          check("result_latency", cyc - fall_cyc, e[48:33]);
        end
        have_read = 1'b1;
        read_cyc  = cyc;
        idle_cnt  = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (!o_idle && n < 1000) begin @(negedge clk); n++; end
    check("return_idle", o_idle, 1);
  endtask

  task automatic start_pulse();
    wait_idle();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("idle_fell", o_idle, 0);
  endtask

  task automatic wait_trig_fall();
    int n = 0;
    while (!o_trig && n < 50) begin @(negedge clk); n++; end
    check("trig_rise_seen", o_trig, 1);
    n = 0;
    while (o_trig && n < 50) begin @(negedge clk); n++; end
    check("trig_fall_seen", o_trig, 0);
  endtask

  task automatic wait_read();
    int n = 0;
    while (!o_read && n < 400) begin @(negedge clk); n++; end
    check("read_seen", o_read, 1);
  endtask

  task automatic echo_pulse(input int d, input int h);
    if (h > 0) begin
      repeat (d) @(negedge clk);
      i_echo = 1'b1;
      repeat (h) @(negedge clk);
      i_echo = 1'b0;
    end
  endtask

  task automatic measure(input int d, input int h);
    start_pulse();
    wait_trig_fall();
    exp_q.push_back(model(d, h));
    echo_pulse(d, h);
    wait_idle();
  endtask

  task automatic async_reset_check(input string tag);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check({tag, "_trig"}, o_trig, 0);
    check({tag, "_read"}, o_read, 0);
    check({tag, "_dist"}, o_distance, 0);
    check({tag, "_idle"}, o_idle, 1);
    check({tag, "_timeout"}, o_timeout, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int trig_cnt;
    int d, h;
    rst     = 1'b0;
    i_start = 1'b0;
    i_echo  = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("rst_trig", o_trig, 0);
    check("rst_read", o_read, 0);
    check("rst_dist", o_distance, 0);
    check("rst_idle", o_idle, 1);
    check("rst_timeout", o_timeout, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    measure(0, 57);
    measure(10, 9);
    measure(0, 0);

    // Echo already high before the trigger: no edge, so the window expires.
    i_echo = 1'b1;
    repeat (4) @(negedge clk);
    start_pulse();
    wait_trig_fall();
    exp_q.push_back(model(0, 0));
    wait_read();
    wait_idle();
    i_echo = 1'b0;
    repeat (4) @(negedge clk);

    measure(10, 260);
    measure(0, 196);
    measure(0, 197);

    // Start request during holdoff must be dropped.
    start_pulse();
    wait_trig_fall();
    exp_q.push_back(model(3, 40));
    echo_pulse(3, 40);
    wait_read();
    repeat (5) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_idle();
    trig_cnt = 0;
    repeat (30) begin @(negedge clk); if (o_trig) trig_cnt++; end
    check("holdoff_start_ignored", trig_cnt, 0);

    // Continuous mode with i_start held high.
    wait_idle();
    i_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_trig_fall();
      cont_chk = 1'b1;
      exp_q.push_back(model(3, 30));
      echo_pulse(3, 30);
      if (k == 2) i_start = 1'b0;
    end
    wait_idle();
    cont_chk = 1'b0;

    // Reset while the trigger is being driven.
    start_pulse();
    repeat (2) @(negedge clk);
    async_reset_check("rst_in_trig");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Leave a timeout result behind, then reset mid-measurement.
    measure(0, 0);
    start_pulse();
    wait_trig_fall();
    repeat (2) @(negedge clk);
    i_echo = 1'b1;
    repeat (20) @(negedge clk);
    async_reset_check("rst_in_measure");
    repeat (2) @(negedge clk);
    i_echo = 1'b0;
    rst    = 1'b0;
    repeat (4) @(negedge clk);
    measure(4, 100);

    for (int r = 0; r < 8; r++) begin
      d = $urandom_range(0, 40);
      if ($urandom_range(0, 3) == 0) h = $urandom_range(150, 240);
      else h = $urandom_range(1, 150);
      measure(d, h);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
